// File: rtl/memory_arbiter.sv
// Round-robin arbiter for four clients in front of the four-port memory controller.
// Grants one client at a time and returns a one-cycle done (or timeout error) pulse.
module memory_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       mem_ready,
  output logic [1:0] sel,
  output logic       mem_en,
  output logic [3:0] grant,
  output logic [3:0] done,
  output logic       error,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_en_q, mem_en_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       done_q, done_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic [1:0]       winner;

  // First requesting client found scanning p, p+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    mem_en_d = 1'b0;
    grant_d  = 4'b0000;
    done_d   = 4'b0000;
    error_d  = 1'b0;
    busy_d   = 1'b0;
    winner   = rr_pick(req, ptr_q);

    case (state_q)
      S_IDLE: begin
        if (req != 4'b0000) begin
          state_d  = S_BUSY;
          sel_d    = winner;
          grant_d  = 4'b0001 << winner;
          cnt_d    = '0;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_BUSY: begin
        // The pointer moves on as the transaction leaves BUSY, so it is already
        // past the served client when the DONE/ERR cycle is on the outputs.
        if (!req[sel_q]) begin
          state_d = S_IDLE;
          ptr_d   = sel_q + 2'd1;
        end else if (cnt_q != '0 && mem_ready) begin
          state_d = S_DONE;
          done_d  = 4'b0001 << sel_q;
          busy_d  = 1'b1;
          ptr_d   = sel_q + 2'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          done_d  = 4'b0001 << sel_q;
          error_d = 1'b1;
          busy_d  = 1'b1;
          ptr_d   = sel_q + 2'd1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          mem_en_d = 1'b1;
          grant_d  = grant_q;
          busy_d   = 1'b1;
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sel_q    <= 2'd0;
      ptr_q    <= 2'd0;
      cnt_q    <= '0;
      mem_en_q <= 1'b0;
      grant_q  <= 4'b0000;
      done_q   <= 4'b0000;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      mem_en_q <= mem_en_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
    end
  end

  assign sel    = sel_q;
  assign mem_en = mem_en_q;
  assign grant  = grant_q;
  assign done   = done_q;
  assign error  = error_q;
  assign busy   = busy_q;

endmodule
